// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte-level helpers and FSM type shared by the cipher and key expansion
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } cipher_state_e;

    // Forward S-box, byte 0x00 at the leftmost (bit 0) position
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*int'(b) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_column(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0  +: 8];
        a1 = c[8  +: 8];
        a2 = c[16 +: 8];
        a3 = c[24 +: 8];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte index is 4*column + row; row r rotates left by r columns
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES encryption round
module aes_round (
    input  logic [0:127] st,
    input  logic [0:127] rk,
    input  logic         final_rnd,
    output logic [0:127] nxt
);
    import aes_pkg::*;

    logic [0:127] w_sr;
    logic [0:127] w_mc;

    assign w_sr = shift_rows(sub_bytes(st));
    assign w_mc = {mix_column(w_sr[0  +: 32]), mix_column(w_sr[32 +: 32]),
                   mix_column(w_sr[64 +: 32]), mix_column(w_sr[96 +: 32])};
    assign nxt  = (final_rnd ? w_sr : w_mc) ^ rk;

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES encryption core, one round per clock
module aes_cipher_iter #(
    parameter int NR = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:127]             plaintext,
    input  logic [0:128*(NR+1)-1]    w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:127]             ciphertext
);
    import aes_pkg::*;

    localparam int              RW       = $clog2(NR + 1);
    localparam logic [RW-1:0]   LAST_RND = RW'(NR);

    cipher_state_e  r_state;
    logic [RW-1:0]  r_rnd;
    logic [0:127]   r_st;
    logic           r_out_valid;

    logic [0:127]   w_rk;
    logic [0:127]   w_nxt;
    logic           w_last;
    logic           w_accept;

    assign w_rk     = w[128*int'(r_rnd) +: 128];
    assign w_last   = (r_rnd == LAST_RND);
    // Popping the result frees the core in the same cycle, so a new block may enter
    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_valid  = r_out_valid;
    assign ciphertext = r_st;

    aes_round u_round (
        .st        (r_st),
        .rk        (w_rk),
        .final_rnd (w_last),
        .nxt       (w_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rnd       <= '0;
            r_st        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_st    <= plaintext ^ w[0 +: 128];
                        r_rnd   <= RW'(1);
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_st <= w_nxt;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                    if (w_accept) begin
                        r_st    <= plaintext ^ w[0 +: 128];
                        r_rnd   <= RW'(1);
                        r_state <= S_ROUND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - self-checking bench for aes_cipher_iter (AES-128)
module tb_aes_cipher_iter;

    localparam int NR   = 10;
    localparam int WW   = 128 * (NR + 1);
    localparam int NBLK = 1000;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:127]    plaintext;
    logic [0:WW-1]   w;
    logic            out_valid;
    logic            out_ready;
    logic [0:127]    ciphertext;

    aes_cipher_iter #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .w          (w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [0:127] key;
        logic [0:127] pt;
        logic [0:127] ct;
        int           stall;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [0:WW-1] expand(input logic [0:127] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:WW-1] r;
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 4; i++) wd[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[32*i +: 32] = wd[i];
        return r;
    endfunction

    function automatic logic [0:127] ref_enc(input logic [0:127] pt, input logic [0:WW-1] wk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ wk[8*i +: 8];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = t[4*((c + row) % 4) + row];
            if (r < NR) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        s[4*c + row] = gmul(8'h02, t[4*c + row]) ^ gmul(8'h03, t[4*c + (row+1)%4])
                                     ^ t[4*c + (row+2)%4] ^ t[4*c + (row+3)%4];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ wk[128*r + 8*i +: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start(input logic [0:127] key, input logic [0:127] pt);
        w         = expand(key);
        plaintext = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        plaintext = rand128();
    endtask

    task automatic wait_out(inout int lat);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [0:127] exp_q [$];

    initial begin
        int           lat;
        int           n;
        int           got;
        int           ts [2];
        int           pushes;
        int           pops;
        int           cyc;
        logic         can_load;
        logic [0:WW-1] cur_w;

        build_sbox();
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 5};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; w = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_ciphertext", ciphertext, 128'h0);
        chk("reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 3; i++) begin
            start(vecs[i].key, vecs[i].pt);
            lat = 1;
            if (i == 1) begin
                @(posedge clk); #1;
                lat = 2;
                chk("b_round1_state", dut.r_st, 128'ha49c7ff2689f352b6b5bea43026a5049);
            end
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), lat, 11);
            chk($sformatf("vec%0d_ct", i), ciphertext, vecs[i].ct);
            for (int s = 0; s < vecs[i].stall; s++) begin
                @(posedge clk); #1;
                chk($sformatf("vec%0d_hold_valid", i), out_valid, 1'b1);
                chk($sformatf("vec%0d_hold_ct", i), ciphertext, vecs[i].ct);
                chk($sformatf("vec%0d_hold_in_ready", i), in_ready, 1'b0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_popped", i), out_valid, 1'b0);
            out_ready = 1'b0;
        end

        // Back-to-back: in_valid held high throughout, next block enters on the pop cycle
        w = expand(vecs[0].key); plaintext = vecs[0].pt; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n = 1; got = 0; ts[0] = 0; ts[1] = 0;
        while (got < 2 && n < 60) begin
            if (out_valid) begin
                ts[got] = n;
                chk($sformatf("b2b_ct%0d", got), ciphertext, vecs[got].ct);
                if (got == 0) begin
                    w = expand(vecs[1].key);
                    plaintext = vecs[1].pt;
                end else begin
                    in_valid = 1'b0;
                end
                got++;
            end else begin
                plaintext = rand128();
            end
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_first_latency", ts[0], 11);
        chk("b2b_gap", ts[1] - ts[0], 11);
        chk("b2b_idle_after", out_valid, 1'b0);
        out_ready = 1'b0;

        // Reset during round 5 aborts the block silently
        start(vecs[0].key, vecs[0].pt);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_ciphertext", ciphertext, 128'h0);
        chk("abort_in_ready", in_ready, 1'b1);
        start(vecs[1].key, vecs[1].pt);
        lat = 1;
        wait_out(lat);
        chk("abort_next_latency", lat, 11);
        chk("abort_next_ct", ciphertext, vecs[1].ct);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Random traffic against the reference model; w only changes while no block is in flight
        pushes = 0; pops = 0; cyc = 0; cur_w = w;
        while (pops < NBLK && cyc < 40000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            can_load  = (exp_q.size() == 0) || (out_valid && out_ready);
            if (can_load) begin
                cur_w     = expand(rand128());
                w         = cur_w;
                plaintext = rand128();
                in_valid  = (pushes < NBLK) && ($urandom_range(0, 3) != 0);
            end else begin
                plaintext = rand128();
                in_valid  = ($urandom_range(0, 1) != 0);
            end
            #1;
            chk("rand_in_ready", in_ready, can_load);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_extra_block: got %h expected no output", ciphertext);
                end else begin
                    chk("rand_ct", ciphertext, exp_q.pop_front());
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_enc(plaintext, cur_w));
                pushes++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_block_count", pops, NBLK);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
